// File: rtl/oled_pkg.sv
// Shared types and SSD1306 command constants for the OLED SPI controller.
package oled_pkg;

   typedef enum logic [3:0] {
      ST_PRE_RESET,
      ST_RESET_LOW,
      ST_POST_RESET,
      ST_INIT,
      ST_CLEAR,
      ST_IDLE,
      ST_HOST_CMD,
      ST_WINDOW,
      ST_DRAW
   } state_e;

   localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
   localparam logic [7:0] CMD_DISP_ON     = 8'hAF;
   localparam logic [7:0] CMD_ADDR_MODE   = 8'h20;
   localparam logic [7:0] CMD_HORIZ_MODE  = 8'h00;
   localparam logic [7:0] CMD_CONTRAST    = 8'h81;
   localparam logic [7:0] CONTRAST_VAL    = 8'h7F;
   localparam logic [7:0] CMD_RESUME_RAM  = 8'hA4;
   localparam logic [7:0] CMD_NORMAL      = 8'hA6;
   localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
   localparam logic [7:0] CMD_CHARGE_EN   = 8'h14;
   localparam logic [7:0] CMD_COL_ADDR    = 8'h21;
   localparam logic [7:0] CMD_PAGE_ADDR   = 8'h22;

   localparam int INIT_LEN = 10;

   // Element 0 is sent first.
   localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
      CMD_DISP_ON, CMD_CHARGE_EN, CMD_CHARGE_PUMP, CMD_RESUME_RAM, CMD_NORMAL,
      CONTRAST_VAL, CMD_CONTRAST, CMD_HORIZ_MODE, CMD_ADDR_MODE, CMD_DISP_OFF
   };

endpackage

// File: rtl/oled_spi_ctrl_if.sv
// Panel, framebuffer and host-command signals of the OLED controller.
// master = controller side, slave = panel/framebuffer/host side.
interface oled_spi_ctrl_if #(parameter int FB_AW = 10);
   logic             sclk;
   logic             sdin;
   logic             res_n;
   logic             dc;
   logic             cs_n;
   logic [FB_AW-1:0] fb_rd_addr;
   logic [7:0]       fb_rd_data;
   logic             frame_req;
   logic             frame_done;
   logic             cmd_valid;
   logic [7:0]       cmd_byte;
   logic             cmd_ready;
   logic             busy;

   modport master (
      output sclk, sdin, res_n, dc, cs_n, fb_rd_addr, frame_done, cmd_ready, busy,
      input  fb_rd_data, frame_req, cmd_valid, cmd_byte
   );

   modport slave (
      input  sclk, sdin, res_n, dc, cs_n, fb_rd_addr, frame_done, cmd_ready, busy,
      output fb_rd_data, frame_req, cmd_valid, cmd_byte
   );
endinterface

// File: rtl/oled_spi_ctrl_spi_byte_tx.sv
// One SPI mode-0 byte, MSB first: 16 half-periods of CLK_DIV clocks with
// cs_n low, then cs_n high for one cycle while done pulses.
module spi_byte_tx #(
   parameter int CLK_DIV = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_i,
   input  logic [7:0] byte_i,
   input  logic       dc_i,
   output logic       sclk_o,
   output logic       sdin_o,
   output logic       cs_n_o,
   output logic       dc_o,
   output logic       done_o
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic          active_q;
   logic [DW-1:0] div_q;
   logic [3:0]    ph_q;
   logic [7:0]    sh_q;
   logic          sclk_q, sdin_q, cs_n_q, dc_q, done_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         active_q <= 1'b0;
         div_q    <= '0;
         ph_q     <= '0;
         sh_q     <= '0;
         sclk_q   <= 1'b0;
         sdin_q   <= 1'b0;
         cs_n_q   <= 1'b1;
         dc_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (!active_q) begin
            if (start_i) begin
               active_q <= 1'b1;
               div_q    <= '0;
               ph_q     <= '0;
               sh_q     <= byte_i;
               sdin_q   <= byte_i[7];
               cs_n_q   <= 1'b0;
               dc_q     <= dc_i;
            end
         end else if (div_q == DW'(CLK_DIV - 1)) begin
            div_q <= '0;
            ph_q  <= ph_q + 4'd1;
            if (!ph_q[0]) begin
               sclk_q <= 1'b1;
            end else begin
               sclk_q <= 1'b0;
               // Final falling edge closes the byte; data shifts on the others.
               if (ph_q == 4'hF) begin
                  active_q <= 1'b0;
                  cs_n_q   <= 1'b1;
                  done_q   <= 1'b1;
               end else begin
                  sdin_q <= sh_q[6];
                  sh_q   <= {sh_q[6:0], 1'b0};
               end
            end
         end else begin
            div_q <= div_q + 1'b1;
         end
      end
   end

   assign sclk_o = sclk_q;
   assign sdin_o = sdin_q;
   assign cs_n_o = cs_n_q;
   assign dc_o   = dc_q;
   assign done_o = done_q;
endmodule

// File: rtl/oled_spi_ctrl.sv
// SSD1306 OLED controller: power-up reset, init, clear, framebuffer refresh
// and host command injection. OLED_ADDR_WINDOW_EN resends the address window per frame.
module oled_spi_ctrl
   import oled_pkg::*;
#(
   parameter int DISPLAY_WIDTH  = 128,
   parameter int DISPLAY_HEIGHT = 64,
   parameter int CLK_DIV        = 1,
   parameter int STARTUP_DELAY  = 10000000,
   parameter int FRAME_DELAY    = 270000,
   parameter int FB_AW          = $clog2(DISPLAY_WIDTH * (DISPLAY_HEIGHT / 8))
) (
   input  logic             clk,
   input  logic             reset,
   oled_spi_ctrl_if.master  bus
);
   localparam int PAGES = DISPLAY_HEIGHT / 8;
   localparam int IW    = FB_AW + 1;
   localparam logic [IW-1:0] NB = IW'(DISPLAY_WIDTH * PAGES);

   state_e           state_q, state_d, nxt;
   logic [31:0]      cnt_q, cnt_d;
   logic [31:0]      timer_q, timer_d;
   logic [IW-1:0]    idx_q, idx_d, limit;
   logic [FB_AW-1:0] addr_q, addr_d;
   logic [7:0]       cmd_q, cmd_d;
   logic             pend_q, pend_d;
   logic             fdone_q, fdone_d;
   logic             inflight_q, inflight_d;
   logic             sending, timer_hit;
   logic             tx_start, tx_dc, tx_done;
   logic [7:0]       tx_byte;
   logic             tx_sclk, tx_sdin, tx_cs_n, tx_dc_o;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_PRE_RESET;
         cnt_q      <= '0;
         timer_q    <= '0;
         idx_q      <= '0;
         addr_q     <= '0;
         cmd_q      <= '0;
         pend_q     <= 1'b0;
         fdone_q    <= 1'b0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         timer_q    <= timer_d;
         idx_q      <= idx_d;
         addr_q     <= addr_d;
         cmd_q      <= cmd_d;
         pend_q     <= pend_d;
         fdone_q    <= fdone_d;
         inflight_q <= inflight_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      timer_d    = timer_q;
      idx_d      = idx_q;
      addr_d     = addr_q;
      cmd_d      = cmd_q;
      pend_d     = pend_q | bus.frame_req;
      fdone_d    = 1'b0;
      inflight_d = inflight_q;
      sending    = 1'b0;
      timer_hit  = 1'b0;
      limit      = '0;
      nxt        = ST_IDLE;
      tx_byte    = 8'h00;
      tx_dc      = 1'b0;
      tx_start   = 1'b0;

      case (state_q)
         ST_PRE_RESET, ST_RESET_LOW, ST_POST_RESET: begin
            cnt_d = cnt_q + 32'd1;
            if (cnt_q == 32'(STARTUP_DELAY - 1)) begin
               cnt_d   = '0;
               state_d = (state_q == ST_PRE_RESET) ? ST_RESET_LOW :
                         (state_q == ST_RESET_LOW) ? ST_POST_RESET : ST_INIT;
            end
         end
         ST_INIT: begin
            sending = 1'b1;
            limit   = IW'(INIT_LEN);
            nxt     = ST_CLEAR;
            tx_byte = (idx_q < IW'(INIT_LEN)) ? INIT_ROM[idx_q[3:0]] : 8'h00;
         end
         ST_CLEAR: begin
            sending = 1'b1;
            limit   = NB;
            nxt     = ST_IDLE;
            tx_dc   = 1'b1;
         end
         ST_IDLE: begin
            if (FRAME_DELAY != 0) begin
               timer_d = timer_q + 32'd1;
               if (timer_q == 32'(FRAME_DELAY - 1)) begin
                  timer_hit = 1'b1;
                  timer_d   = '0;
               end
            end
            // A host command goes first; any refresh trigger stays pending.
            if (bus.cmd_valid) begin
               cmd_d   = bus.cmd_byte;
               pend_d  = pend_q | bus.frame_req | timer_hit;
               state_d = ST_HOST_CMD;
            end else if (pend_q || bus.frame_req || timer_hit) begin
               pend_d  = 1'b0;
`ifdef OLED_ADDR_WINDOW_EN
               state_d = ST_WINDOW;
`else
               state_d = ST_DRAW;
`endif
            end
         end
         ST_HOST_CMD: begin
            sending = 1'b1;
            limit   = IW'(1);
            nxt     = ST_IDLE;
            tx_byte = cmd_q;
         end
         ST_WINDOW: begin
            sending = 1'b1;
            limit   = IW'(6);
            nxt     = ST_DRAW;
            case (idx_q[2:0])
               3'd0:    tx_byte = CMD_COL_ADDR;
               3'd2:    tx_byte = 8'(DISPLAY_WIDTH - 1);
               3'd3:    tx_byte = CMD_PAGE_ADDR;
               3'd5:    tx_byte = 8'(PAGES - 1);
               default: tx_byte = 8'h00;
            endcase
         end
         ST_DRAW: begin
            sending = 1'b1;
            limit   = NB;
            nxt     = ST_IDLE;
            tx_dc   = 1'b1;
            tx_byte = bus.fb_rd_data;
         end
         default: state_d = ST_PRE_RESET;
      endcase

      // The next byte starts in the cs_n-high gap cycle of the previous one.
      if (sending) begin
         tx_start = (!inflight_q || tx_done) && (idx_q < limit);
         if (tx_start) begin
            idx_d = idx_q + 1'b1;
            if (state_q == ST_DRAW)
               addr_d = (idx_q + 1'b1 == NB) ? '0 : FB_AW'(idx_q + 1'b1);
         end
         if (tx_done && idx_q == limit) begin
            idx_d   = '0;
            state_d = nxt;
            fdone_d = (state_q == ST_DRAW);
            if (state_q == ST_DRAW) addr_d = '0;
         end
      end

      if (tx_start)     inflight_d = 1'b1;
      else if (tx_done) inflight_d = 1'b0;
   end

   spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
      .clk    (clk),
      .reset  (reset),
      .start_i(tx_start),
      .byte_i (tx_byte),
      .dc_i   (tx_dc),
      .sclk_o (tx_sclk),
      .sdin_o (tx_sdin),
      .cs_n_o (tx_cs_n),
      .dc_o   (tx_dc_o),
      .done_o (tx_done)
   );

   assign bus.sclk       = tx_sclk;
   assign bus.sdin       = tx_sdin;
   assign bus.cs_n       = tx_cs_n;
   assign bus.dc         = tx_dc_o;
   assign bus.res_n      = (state_q != ST_RESET_LOW);
   assign bus.fb_rd_addr = addr_q;
   assign bus.frame_done = fdone_q;
   assign bus.cmd_ready  = (state_q == ST_IDLE);
   assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_oled_spi_ctrl.sv
// Bench for oled_spi_ctrl: decodes the SPI stream and compares it against
// hand-built expected byte sequences and a host-command vector table.
module tb_oled_spi_ctrl;
   localparam int W   = 16;
   localparam int H   = 16;
   localparam int PG  = H / 8;
   localparam int NB  = W * PG;
   localparam int SD  = 4;
   localparam int AW  = $clog2(NB);
`ifdef OLED_ADDR_WINDOW_EN
   localparam int CD  = 3;
   localparam int WIN = 6;
`else
   localparam int CD  = 1;
   localparam int WIN = 0;
`endif
   localparam int PER = 16 * CD + 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   oled_spi_ctrl_if #(.FB_AW(AW)) bus();

   oled_spi_ctrl #(
      .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .CLK_DIV(CD),
      .STARTUP_DELAY(SD), .FRAME_DELAY(0), .FB_AW(AW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   logic [7:0] mem [NB];
   always @(posedge clk) bus.fb_rd_data <= mem[bus.fb_rd_addr];

   typedef struct {logic dc; logic [7:0] b; int t;} rx_t;
   rx_t        rxq[$];
   logic [8:0] expq[$];
   logic [7:0] init_b [10];

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int fd_cnt = 0;
   int dc_bad = 0;
   int hi_min = 1000;
   int hi_max = 0;
   int rise_lat = -1;

   always @(posedge clk) cyc <= cyc + 1;

   // SPI decoder: samples away from the clock edge.
   initial begin
      logic prev_cs, prev_sclk, dc_at;
      logic [7:0] sh;
      int bitcnt, t_fall, hi_run;
      prev_cs = 1'b1; prev_sclk = 1'b0; dc_at = 1'b0; sh = '0;
      bitcnt = 0; t_fall = 0; hi_run = 0;
      forever begin
         @(negedge clk);
         if (bus.frame_done === 1'b1) fd_cnt++;
         if (reset) begin
            prev_cs = 1'b1; prev_sclk = 1'b0; bitcnt = 0; hi_run = 0;
         end else begin
            if (prev_cs && !bus.cs_n) begin
               bitcnt = 0; sh = '0; t_fall = cyc; dc_at = bus.dc;
            end
            if (!bus.cs_n && bus.dc !== dc_at) dc_bad++;
            if (!prev_sclk && bus.sclk && !bus.cs_n) begin
               sh = {sh[6:0], bus.sdin};
               bitcnt++;
               if (bitcnt == 1) rise_lat = cyc - t_fall;
            end
            if (bus.sclk) hi_run++;
            else if (prev_sclk) begin
               if (hi_run < hi_min) hi_min = hi_run;
               if (hi_run > hi_max) hi_max = hi_run;
               hi_run = 0;
            end
            if (!prev_cs && bus.cs_n && bitcnt == 8) rxq.push_back('{dc_at, sh, t_fall});
            prev_cs = bus.cs_n; prev_sclk = bus.sclk;
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic settle(input string nm);
      int quiet = 0;
      int i = 0;
      while (i < 30000 && quiet < 20) begin
         @(negedge clk);
         i++;
         if (bus.busy === 1'b0) quiet++; else quiet = 0;
      end
      chk({nm, " reaches idle"}, int'(quiet >= 20), 1);
   endtask

   task automatic meas_reset(input string nm);
      int pre = 0;
      int lo = 0;
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.res_n === 1'b0) break;
         pre++;
      end
      for (int i = 0; i < 100; i++) begin
         if (bus.res_n !== 1'b0) break;
         lo++;
         @(negedge clk);
      end
      chk({nm, " pre-reset cycles"}, pre, SD - 1);
      chk({nm, " res_n low cycles"}, lo, SD);
   endtask

   task automatic push_init();
      for (int i = 0; i < 10; i++) expq.push_back({1'b0, init_b[i]});
      for (int i = 0; i < NB; i++) expq.push_back(9'h100);
   endtask

   task automatic push_frame();
      if (WIN != 0) begin
         expq.push_back(9'h021); expq.push_back(9'h000); expq.push_back(9'(W - 1));
         expq.push_back(9'h022); expq.push_back(9'h000); expq.push_back(9'(PG - 1));
      end
      for (int k = 0; k < NB; k++) expq.push_back({1'b1, 8'(k)});
   endtask

   task automatic check_stream(input string nm);
      chk({nm, " byte count"}, rxq.size(), expq.size());
      for (int i = 0; i < expq.size() && i < rxq.size(); i++)
         chk($sformatf("%s byte%0d", nm, i), int'({rxq[i].dc, rxq[i].b}), int'(expq[i]));
      rxq.delete();
      expq.delete();
   endtask

   task automatic pulse_req();
      bus.frame_req = 1'b1;
      @(negedge clk);
      bus.frame_req = 1'b0;
   endtask

   typedef struct {
      logic [7:0] cmd;
      bit         req;
      int         exp_n;
      int         exp_fd;
      logic [8:0] exp_first;
   } hv_t;
   hv_t tv [4];

   initial begin
      int fd0, bad;
      init_b = '{8'hAE, 8'h20, 8'h00, 8'h81, 8'h7F, 8'hA6, 8'hA4, 8'h8D, 8'h14, 8'hAF};
      tv[0] = '{8'hA7, 1'b1, 1 + WIN + NB, 1, 9'h0A7};
      tv[1] = '{8'h81, 1'b0, 1,            0, 9'h081};
      tv[2] = '{8'hA6, 1'b0, 1,            0, 9'h0A6};
      tv[3] = '{8'hAF, 1'b1, 1 + WIN + NB, 1, 9'h0AF};
      for (int k = 0; k < NB; k++) mem[k] = 8'(k);
      bus.frame_req = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_byte  = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst sclk",       int'(bus.sclk), 0);
      chk("rst sdin",       int'(bus.sdin), 0);
      chk("rst res_n",      int'(bus.res_n), 1);
      chk("rst dc",         int'(bus.dc), 0);
      chk("rst cs_n",       int'(bus.cs_n), 1);
      chk("rst fb_rd_addr", int'(bus.fb_rd_addr), 0);
      chk("rst frame_done", int'(bus.frame_done), 0);
      chk("rst cmd_ready",  int'(bus.cmd_ready), 0);
      chk("rst busy",       int'(bus.busy), 1);

      // Power-up: reset pulse, init, clear
      meas_reset("powerup");
      settle("powerup");
      push_init();
      check_stream("init");
      chk("init frame_done", fd_cnt, 0);

      // Single requested frame with ramp framebuffer
      fd0 = fd_cnt;
      @(negedge clk);
      pulse_req();
      settle("frame");
      chk("frame frame_done", fd_cnt - fd0, 1);
      bad = 0;
      for (int i = WIN; i + 1 < rxq.size(); i++)
         if (rxq[i+1].t - rxq[i].t != PER) bad++;
      chk("frame bad byte periods", bad, 0);
      if (rxq.size() > WIN + 1) chk("frame byte period", rxq[WIN+1].t - rxq[WIN].t, PER);
      chk("sclk rise latency", rise_lat, CD);
      chk("sclk high min", hi_min, CD);
      chk("sclk high max", hi_max, CD);
      push_frame();
      check_stream("frame");

      // Host command table, optionally colliding with frame_req
      for (int t = 0; t < 4; t++) begin
         fd0 = fd_cnt;
         @(negedge clk);
         chk($sformatf("hv%0d cmd_ready", t), int'(bus.cmd_ready), 1);
         bus.cmd_valid = 1'b1;
         bus.cmd_byte  = tv[t].cmd;
         bus.frame_req = tv[t].req;
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         bus.frame_req = 1'b0;
         settle($sformatf("hv%0d", t));
         chk($sformatf("hv%0d count", t), rxq.size(), tv[t].exp_n);
         if (rxq.size() > 0)
            chk($sformatf("hv%0d first", t), int'({rxq[0].dc, rxq[0].b}), int'(tv[t].exp_first));
         chk($sformatf("hv%0d frame_done", t), fd_cnt - fd0, tv[t].exp_fd);
         if (tv[t].req && rxq.size() == 1 + WIN + NB)
            for (int k = 0; k < NB; k++)
               chk($sformatf("hv%0d data%0d", t, k), int'({rxq[1+WIN+k].dc, rxq[1+WIN+k].b}),
                   int'({1'b1, 8'(k)}));
         rxq.delete();
      end

      // Three requests during a refresh collapse into one more frame
      fd0 = fd_cnt;
      pulse_req();
      for (int r = 0; r < 3; r++) begin
         repeat (40) @(negedge clk);
         pulse_req();
      end
      chk("refresh busy", int'(bus.busy), 1);
      chk("refresh cmd_ready held off", int'(bus.cmd_ready), 0);
      settle("collapse");
      chk("collapse frame_done", fd_cnt - fd0, 2);
      push_frame();
      push_frame();
      check_stream("collapse");

      // Reset in the middle of a data byte
      fd0 = fd_cnt;
      pulse_req();
      bad = 1;
      for (int i = 0; i < 2000; i++) begin
         if (bus.cs_n === 1'b0 && bus.dc === 1'b1) begin bad = 0; break; end
         @(negedge clk);
      end
      chk("midreset found data byte", bad, 0);
      repeat (3 * CD) @(negedge clk);
      reset = 1'b1;
      rxq.delete();
      @(negedge clk);
      chk("midreset cs_n",  int'(bus.cs_n), 1);
      chk("midreset sclk",  int'(bus.sclk), 0);
      chk("midreset res_n", int'(bus.res_n), 1);
      chk("midreset busy",  int'(bus.busy), 1);
      chk("midreset addr",  int'(bus.fb_rd_addr), 0);
      repeat (2) @(negedge clk);
      meas_reset("midreset");
      settle("midreset");
      chk("midreset frame_done", fd_cnt - fd0, 0);
      push_init();
      check_stream("reinit");
      chk("dc stable within byte", dc_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/oled_spi_ctrl.md
Name: oled_spi_ctrl

Overview:
Parametrised SSD1306-class OLED controller over 4-wire SPI. It performs the power-up reset and init sequence, then clears the panel. After that it refreshes the panel from an external page-organised framebuffer, either on a timer or on request. A host command port injects single command bytes (contrast, invert, etc.) between frames, and SPI speed is configurable.

Parameters:
DISPLAY_WIDTH, 128, columns (power of 2, 8..128)
DISPLAY_HEIGHT, 64, rows (multiple of 8, 8..64); PAGES = DISPLAY_HEIGHT/8
CLK_DIV, 1, clk cycles per SCLK half-period (>=1)
STARTUP_DELAY, 10000000, clk cycles for each of pre-reset, reset-low and post-reset phases
FRAME_DELAY, 270000, clk cycles between automatic refreshes; 0 disables auto refresh
FB_AW, $clog2(DISPLAY_WIDTH*PAGES), framebuffer address width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; restarts the whole sequence
sclk  out  1  SPI clock, idle low
sdin  out  1  SPI data, MSB first, sampled by panel on SCLK rise
res_n  out  1  panel reset, active low
dc  out  1  0 = command, 1 = data
cs_n  out  1  chip select, active low
fb_rd_addr  out  FB_AW  byte address = page*DISPLAY_WIDTH + column
fb_rd_data  in  8  byte at fb_rd_addr, valid exactly 1 cycle after address
frame_req  in  1  pulse: request a refresh
frame_done  out  1  1-cycle pulse after last byte of a frame
cmd_valid  in  1  host command byte valid
cmd_byte  in  8  host command byte
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values (next edge after reset high): sclk 0, sdin 0, res_n 1, dc 0, cs_n 1, fb_rd_addr 0, frame_done 0, cmd_ready 0, busy 1. State returns to PRE_RESET and all counters clear, including mid-byte; no partial byte completes.
- States: PRE_RESET -> RESET_LOW -> POST_RESET. Each lasts STARTUP_DELAY cycles; res_n is 0 only in RESET_LOW. Then INIT -> CLEAR -> IDLE, with IDLE -> {HOST_CMD, WINDOW, DRAW} -> IDLE.
- INIT: sends command bytes (dc=0) AE,20,00,81,7F,A6,A4,8D,14,AF in order.
- CLEAR: sends DISPLAY_WIDTH*PAGES bytes of 00 (dc=1).
- Byte transfer (spi_byte_tx):
  - cs_n falls and sdin=bit7 on the start cycle. sclk goes high after CLK_DIV cycles, low after another CLK_DIV.
  - 8 bits take 16*CLK_DIV cycles, then cs_n=1 for exactly 1 cycle, so the byte period is 16*CLK_DIV+1.
  - dc is stable for the whole byte.
- IDLE: cmd_ready=1. Frame timer increments; a refresh starts when the timer reaches FRAME_DELAY (timer clears) or when frame_req is pending.
  - If cmd_valid and a refresh trigger occur in the same cycle, the host command wins and the refresh stays pending.
- HOST_CMD: sends cmd_byte (captured at handshake) with dc=0, then returns to IDLE.
- DRAW: column-major within page, pages 0..PAGES-1, dc=1.
  - fb_rd_addr is issued one cycle before each byte starts, so data is captured with exactly 1 cycle latency.
  - After the last byte: frame_done pulses and the state returns to IDLE.
- frame_req arriving outside IDLE or during a refresh is latched as one pending request. Multiple requests collapse into one.
- cmd_valid outside IDLE is held off (cmd_ready=0); the host must hold cmd_valid.
- Addressing wraps in the panel's horizontal mode. The controller never sends more than DISPLAY_WIDTH*PAGES data bytes per frame.

Optional Feature:
OLED_ADDR_WINDOW_EN
- Defined: each refresh enters WINDOW before DRAW and sends commands 21,00,DISPLAY_WIDTH-1,22,00,PAGES-1 (dc=0). This resynchronises the panel pointer after a host command or glitch.
- Undefined: IDLE goes directly to DRAW and relies on pointer wrap.

Decomposition:
- Package oled_pkg: state enum; SSD1306 command constants (AE, AF, 20, 00, 81, A4, A6, 8D, 14, 21, 22); init ROM as a constant array and its length.
- Sub-module spi_byte_tx (params CLK_DIV):
  - inputs: start, byte, dc_in
  - outputs: sclk, sdin, cs_n, dc, done (1-cycle pulse)

Test Plan (W=16, H=16, CLK_DIV=1, STARTUP_DELAY=4, FRAME_DELAY=0):
- Release reset -> res_n low for exactly 4 cycles; next, decoded SPI shows AE,20,00,81,7F,A6,A4,8D,14,AF with dc=0, then 32 bytes 00 with dc=1; busy falls.
- Framebuffer byte k = k, then frame_req pulse -> 32 bytes 00..1F in order with dc=1; frame_done pulses once; each byte spans 17 cycles incl. 1-cycle cs_n high gap.
- cmd_valid with cmd_byte=A7 asserted at the same cycle as frame_req in IDLE -> A7 sent first (dc=0), then the full frame.
- frame_req pulsed 3 times during a refresh -> exactly one additional frame follows.
- Reset asserted mid-byte during DRAW -> next cycle cs_n=1, sclk=0, res_n=1; the full reset/init sequence repeats.
- With OLED_ADDR_WINDOW_EN, CLK_DIV=3 -> each frame is preceded by 21,00,0F,22,00,01; SCLK half-period is 3 cycles.
